// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 phase sequencer: FSM state encoding,
// S-memory widths and the LED phase codes.
package rc4_pkg;

    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHUF,
        ST_DEC,
        ST_DONE,
        ST_ERROR
    } rc4_phase_t;

    localparam logic [1:0] PHASE_IDLE = 2'd0;
    localparam logic [1:0] PHASE_INIT = 2'd1;
    localparam logic [1:0] PHASE_SHUF = 2'd2;
    localparam logic [1:0] PHASE_DEC  = 2'd3;

    function automatic logic [1:0] phase_code(input rc4_phase_t s);
        case (s)
            ST_INIT: phase_code = PHASE_INIT;
            ST_SHUF: phase_code = PHASE_SHUF;
            ST_DEC:  phase_code = PHASE_DEC;
            default: phase_code = PHASE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase stall detector: counts cycles spent in the current phase and flags
// expiry on the last allowed cycle. TIMEOUT_CYCLES of 0 disables it.
module phase_watchdog
    import rc4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [11:0] LIMIT = (TIMEOUT_CYCLES == 0) ? 12'd0 : 12'(TIMEOUT_CYCLES - 1);

    logic [11:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 12'd1;
        end
    end

    assign expired = enable && (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Sequences the RC4 init / shuffle / decrypt phases, owns the single S-memory
// port mux, restarts the chain on a new key and flags stalled phases.
module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                key_start,
    input  logic                init_done,
    input  logic                shuf_done,
    input  logic                dec_done,
    input  logic [S_ADDR_W-1:0] init_addr,
    input  logic [S_ADDR_W-1:0] shuf_addr,
    input  logic [S_ADDR_W-1:0] dec_addr,
    input  logic [S_DATA_W-1:0] init_data,
    input  logic [S_DATA_W-1:0] shuf_data,
    input  logic [S_DATA_W-1:0] dec_data,
    input  logic                init_wren,
    input  logic                shuf_wren,
    input  logic                dec_wren,
    output logic                init_start,
    output logic                shuf_start,
    output logic                dec_start,
    output logic                client_reset,
    output logic [S_ADDR_W-1:0] s_addr,
    output logic [S_DATA_W-1:0] s_data,
    output logic                s_wren,
    output logic [1:0]          phase,
    output logic                busy,
    output logic                done,
    output logic                error
);

    rc4_phase_t state;
    rc4_phase_t next_state;
    logic       in_phase;
    logic       phase_entry;
    logic       wd_expired;

    assign in_phase = (state == ST_INIT) || (state == ST_SHUF) || (state == ST_DEC);

    // key_start outranks done, done outranks expiry; a done in the start cycle
    // is still the previous owner's pulse and is dropped via the start flag.
    always_comb begin
        next_state = state;
        if (key_start) begin
            next_state = ST_INIT;
        end else begin
            case (state)
                ST_INIT: if (init_done && !init_start)      next_state = ST_SHUF;
                         else if (wd_expired)               next_state = ST_ERROR;
                ST_SHUF: if (shuf_done && !shuf_start)      next_state = ST_DEC;
                         else if (wd_expired)               next_state = ST_ERROR;
                ST_DEC:  if (dec_done && !dec_start)        next_state = ST_DONE;
                         else if (wd_expired)               next_state = ST_ERROR;
                default: next_state = state;
            endcase
        end
    end

    assign phase_entry = key_start || ((next_state != state) &&
                         ((next_state == ST_INIT) || (next_state == ST_SHUF) || (next_state == ST_DEC)));

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            init_start   <= 1'b0;
            shuf_start   <= 1'b0;
            dec_start    <= 1'b0;
            client_reset <= 1'b0;
            phase        <= PHASE_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= next_state;
            init_start   <= phase_entry && (next_state == ST_INIT);
            shuf_start   <= phase_entry && (next_state == ST_SHUF);
            dec_start    <= phase_entry && (next_state == ST_DEC);
            client_reset <= key_start;
            phase        <= phase_code(next_state);
            busy         <= (next_state == ST_INIT) || (next_state == ST_SHUF) || (next_state == ST_DEC);
            done         <= (next_state == ST_DONE);
            error        <= (next_state == ST_ERROR);
        end
    end

    phase_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk    (CLOCK_50),
        .reset_n(reset_n),
        .clear  (phase_entry),
        .enable (in_phase),
        .expired(wd_expired)
    );

    always_comb begin
        s_addr = '0;
        s_data = '0;
        s_wren = 1'b0;
        case (state)
            ST_INIT: begin
                s_addr = init_addr;
                s_data = init_data;
                s_wren = init_wren;
            end
            ST_SHUF: begin
                s_addr = shuf_addr;
                s_data = shuf_data;
                s_wren = shuf_wren;
            end
            ST_DEC: begin
                s_addr = dec_addr;
                s_data = dec_data;
                s_wren = dec_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/rc4_phase_sequencer.md
# rc4_phase_sequencer

Sequences the three RC4 phases (S-memory init-by-index, key-schedule shuffle, keystream/decrypt) and arbitrates the single-port S memory among them. Sits between the switch/key front-end and the S memory instance, and owns the S-memory port mux. Issues one-cycle start pulses, collects done pulses, aborts and restarts the whole chain on a new key, and flags a stalled phase via a watchdog.

## Interface
- TIMEOUT_CYCLES, default 4096: per-phase watchdog limit in clock cycles; 0 disables the watchdog.
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- key_start  in  1  pulse: key valid, begin (or restart) the RC4 chain.
- init_done / shuf_done / dec_done  in  1 each  per-client one-cycle completion pulses.
- init_addr / shuf_addr / dec_addr  in  8 each  client S-memory address.
- init_data / shuf_data / dec_data  in  8 each  client S-memory write data.
- init_wren / shuf_wren / dec_wren  in  1 each  client S-memory write enable.
- init_start / shuf_start / dec_start  out  1 each  one-cycle phase start pulses.
- client_reset  out  1  one-cycle active-high reset to all clients on abort/restart.
- s_addr  out  8  S-memory address.
- s_data  out  8  S-memory write data.
- s_wren  out  1  S-memory write enable.
- phase  out  2  current phase code, for LEDs: 0 idle/done, 1 init, 2 shuffle, 3 decrypt.
- busy  out  1  high in INIT, SHUF, DEC.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.

## Operation
- States: IDLE, INIT, SHUF, DEC, DONE, ERROR.
- IDLE/DONE/ERROR + key_start -> INIT.
- INIT + init_done -> SHUF.
- SHUF + shuf_done -> DEC.
- DEC + dec_done -> DONE.
- Any phase state + watchdog expiry -> ERROR.
- key_start in INIT/SHUF/DEC: abort, pulse client_reset, go to INIT.
- Simultaneous key_start and done: key_start wins.
- Simultaneous done and watchdog expiry: done wins.
- Port mux is combinational from the registered state. INIT selects init_*, SHUF selects shuf_*, DEC selects dec_*. Every other state drives s_addr=0, s_data=0, s_wren=0.
- Non-owning clients' wren never reaches memory.
- A done pulse from a non-owning client is ignored.
- Watchdog: 12-bit min counter. Cleared on phase entry, increments each cycle in the phase. Expiry when count == TIMEOUT_CYCLES-1 with no done.

## Timing
- Reset values: state IDLE; all start pulses 0; client_reset 0; s_* 0; phase 0; busy/done/error 0; watchdog 0.
- key_start sampled at edge N -> state INIT from cycle N+1. init_start high during cycle N+1 only, the first cycle of the phase.
- client_reset is high in the same first cycle when entered via key_start (from any state). It is not asserted on normal phase advance.
- Phase advance: done sampled at edge N -> next state from cycle N+1. The next phase's start pulse is high in cycle N+1.
- A done pulse arriving in a phase's start cycle is ignored.
- Mux switches in the same cycle the state changes, so there are zero dead cycles between owners.
- reset_n low mid-phase: next cycle is IDLE with all outputs at reset values; clients are not pulsed.

## Structure
- rc4_pkg holds:
  - the state enum (rc4_phase_t)
  - S_ADDR_W = 8 and S_DATA_W = 8
  - phase code constants
- Sub-module phase_watchdog holds the counter, clear, enable and expired output, parameterised by TIMEOUT_CYCLES.
- The mux stays inline in rc4_phase_sequencer.

## Test plan
- Nominal chain: key_start. Init done at +258, shuffle done at +770, decrypt done at +100 -> exactly one init/shuf/dec start pulse each; phase steps 1,2,3,0; done high; s_wren follows only the owning client.
- Isolation: shuf_wren=1 with shuf_addr=0x55 during INIT -> s_addr = init_addr, no write to 0x55.
- Abort: key_start during SHUF at cycle 300 -> client_reset and init_start in the same cycle; phase=1; watchdog cleared.
- Collision: key_start and shuf_done in the same cycle -> INIT entered, not DEC.
- Watchdog: TIMEOUT_CYCLES=16, no init_done -> error high 16 cycles after init_start; s_wren=0. A later key_start -> INIT, error low.
- Reset: reset_n low for 1 cycle in DEC -> IDLE; all outputs 0 the next cycle.
